// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch sequencer.
// Holds the FSM state encoding plus the default width and memory-timeout constants.
package fetch_pkg;

  localparam int unsigned FETCH_W       = 16;
  localparam int unsigned FETCH_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FULL = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_timer.sv
// 8-bit saturating wait counter for an outstanding memory read.
// expired flags the cycle in which the count reaches limit on the next edge.
module fetch_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       cnt_en,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (cnt_en && (cnt_q < limit)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Compared in 9 bits so a limit of 255 cannot wrap the sum.
  assign expired = cnt_en && !clr && (({1'b0, cnt_q} + 9'd1) >= {1'b0, limit});

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads memory at the current PC into a one-entry
// instruction register, steps/loads the PC, and latches a sticky timeout error.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned W       = FETCH_W,
  parameter int unsigned TIMEOUT = FETCH_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] pc_val,
  output logic         pc_inc,
  output logic         pc_ld,
  output logic [W-1:0] pc_ld_val,
  output logic         mem_rd,
  output logic [W-1:0] mem_addr,
  input  logic         mem_rdy,
  input  logic [W-1:0] mem_rdata,
  output logic [W-1:0] ir_out,
  output logic [W-1:0] ir_pc,
  output logic         ir_valid,
  input  logic         ir_ack,
  input  logic         redirect,
  input  logic [W-1:0] redirect_pc,
  output logic         fetch_err,
  output fetch_state_e dbg_state_o
);

  // Handshake: a read is offered while mem_rd=1 and completes in any cycle where
  // mem_rdy=1 alongside it; the IR is offered while ir_valid=1 and consumed on ir_ack=1.

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  fetch_state_e state_q, state_d;
  logic [W-1:0] ir_out_q, ir_pc_q;
  logic         ir_valid_q;
  logic         ir_load, ir_clr;
  logic         in_req, redir_ok;
  logic         tmr_clr, tmr_en, tmr_expired;

  assign in_req   = (state_q == ST_REQ);
  assign redir_ok = redirect && (state_q != ST_ERR);

  always_comb begin
    state_d = state_q;
    ir_load = 1'b0;
    ir_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ir_clr  = redirect;
        state_d = en ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        // Redirect beats returning data, and returning data beats the timeout.
        if (redirect) begin
          ir_clr  = 1'b1;
          state_d = en ? ST_REQ : ST_IDLE;
        end else if (mem_rdy) begin
          ir_load = 1'b1;
          state_d = ST_FULL;
        end else if (tmr_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_FULL: begin
        if (redirect || ir_ack) begin
          ir_clr  = 1'b1;
          state_d = en ? ST_REQ : ST_IDLE;
        end
      end
      default: begin
        ir_clr  = 1'b1;
        state_d = ST_ERR;
      end
    endcase
  end

  // Dropping mem_rd during a redirect cancels the outstanding read for that cycle.
  assign mem_rd    = !rst && in_req && !redirect;
  assign mem_addr  = pc_val;
  assign pc_inc    = !rst && in_req && !redirect && mem_rdy;
  assign pc_ld     = !rst && redir_ok;
  assign pc_ld_val = redirect_pc;

  assign tmr_clr = !in_req || redirect || mem_rdy;
  assign tmr_en  = in_req && !redirect && !mem_rdy;

  fetch_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .cnt_en  (tmr_en),
    .limit   (LIMIT),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ir_out_q   <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_load) begin
        ir_out_q   <= mem_rdata;
        ir_pc_q    <= pc_val;
        ir_valid_q <= 1'b1;
      end else if (ir_clr) begin
        ir_valid_q <= 1'b0;
      end
    end
  end

  assign ir_out      = ir_out_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_err   = (state_q == ST_ERR);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural PC feeds pc_val, fetched words are
// predicted into a scoreboard queue and checked when the instruction register fills.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic         clk;
  logic         rst;
  logic         en;
  logic [15:0]  pc_val;
  logic         pc_inc;
  logic         pc_ld;
  logic [15:0]  pc_ld_val;
  logic         mem_rd;
  logic [15:0]  mem_addr;
  logic         mem_rdy;
  logic [15:0]  mem_rdata;
  logic [15:0]  ir_out;
  logic [15:0]  ir_pc;
  logic         ir_valid;
  logic         ir_ack;
  logic         redirect;
  logic [15:0]  redirect_pc;
  logic         fetch_err;
  fetch_state_e dbg_state;

  int total;
  int bad;
  logic [31:0] exp_q[$];
  logic [15:0] pc_q;

  fetch_unit #(.W(16), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pc_val      (pc_val),
    .pc_inc      (pc_inc),
    .pc_ld       (pc_ld),
    .pc_ld_val   (pc_ld_val),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdy     (mem_rdy),
    .mem_rdata   (mem_rdata),
    .ir_out      (ir_out),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ack      (ir_ack),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_err   (fetch_err),
    .dbg_state_o (dbg_state)
  );

  // Clock and the program counter the unit drives.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= 16'h0010;
    end else if (pc_inc) begin
      pc_q <= pc_q + 16'd1;
    end else if (pc_ld) begin
      pc_q <= pc_ld_val;
    end
  end
  assign pc_val = pc_q;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic push_ir(input logic [15:0] addr, input logic [15:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic pop_ir();
    logic [31:0] e;
    chk("ir_valid_fill", 32'(ir_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("ir_pc", 32'(ir_pc), 32'(e[31:16]));
      chk("ir_out", 32'(ir_out), 32'(e[15:0]));
    end
  endtask

  initial begin
    logic [15:0] data;
    total = 0;
    bad = 0;
    rst = 1'b1;
    en = 1'b0;
    mem_rdy = 1'b0;
    mem_rdata = '0;
    ir_ack = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'h1234;

    // Reset: outputs forced low even with a redirect pending.
    tick();
    settle();
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_pc_ld", 32'(pc_ld), 32'd0);
    chk("rst_pc_inc", 32'(pc_inc), 32'd0);
    tick();
    rst = 1'b0;
    redirect = 1'b0;
    settle();
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_ir_out", 32'(ir_out), 32'd0);
    chk("rst_ir_pc", 32'(ir_pc), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("idle_mem_rd", 32'(mem_rd), 32'd0);

    // Zero-wait fetch at 0x0010.
    en = 1'b1;
    tick();
    mem_rdy = 1'b1;
    mem_rdata = 16'hA5A5;
    settle();
    chk("zw_mem_rd", 32'(mem_rd), 32'd1);
    chk("zw_mem_addr", 32'(mem_addr), 32'h0010);
    chk("zw_pc_inc", 32'(pc_inc), 32'd1);
    chk("zw_pc_ld", 32'(pc_ld), 32'd0);
    push_ir(16'h0010, 16'hA5A5);
    tick();
    mem_rdy = 1'b0;
    settle();
    pop_ir();
    chk("zw_state_full", 32'(dbg_state), 32'(ST_FULL));
    chk("zw_pc_inc_once", 32'(pc_inc), 32'd0);

    // Backpressure: decode holds off for five cycles.
    for (int i = 0; i < 5; i++) begin
      chk("bp_ir_valid", 32'(ir_valid), 32'd1);
      chk("bp_mem_rd", 32'(mem_rd), 32'd0);
      chk("bp_pc_inc", 32'(pc_inc), 32'd0);
      tick();
      settle();
    end
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    settle();
    chk("ack_ir_valid", 32'(ir_valid), 32'd0);
    chk("ack_state_req", 32'(dbg_state), 32'(ST_REQ));
    chk("ack_mem_addr", 32'(mem_addr), 32'h0011);

    // Three wait states, data on the fourth REQ cycle.
    for (int i = 0; i < 3; i++) begin
      chk("ws_mem_rd", 32'(mem_rd), 32'd1);
      chk("ws_mem_addr", 32'(mem_addr), 32'h0011);
      chk("ws_pc_inc", 32'(pc_inc), 32'd0);
      chk("ws_ir_valid", 32'(ir_valid), 32'd0);
      tick();
      settle();
    end
    data = 16'($urandom_range(0, 65535));
    mem_rdy = 1'b1;
    mem_rdata = data;
    settle();
    chk("ws_mem_addr_last", 32'(mem_addr), 32'h0011);
    chk("ws_pc_inc_last", 32'(pc_inc), 32'd1);
    push_ir(16'h0011, data);
    tick();
    mem_rdy = 1'b0;
    settle();
    pop_ir();

    // Redirect coinciding with returning data: data is dropped.
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    settle();
    chk("rd_pre_addr", 32'(mem_addr), 32'h0012);
    mem_rdy = 1'b1;
    mem_rdata = 16'hDEAD;
    redirect = 1'b1;
    redirect_pc = 16'h0200;
    settle();
    chk("rd_pc_ld", 32'(pc_ld), 32'd1);
    chk("rd_pc_ld_val", 32'(pc_ld_val), 32'h0200);
    chk("rd_pc_inc", 32'(pc_inc), 32'd0);
    chk("rd_mem_rd_drop", 32'(mem_rd), 32'd0);
    tick();
    mem_rdy = 1'b0;
    redirect = 1'b0;
    settle();
    chk("rd_ir_valid", 32'(ir_valid), 32'd0);
    chk("rd_state_req", 32'(dbg_state), 32'(ST_REQ));
    chk("rd_new_addr", 32'(mem_addr), 32'h0200);
    chk("rd_sb_empty", 32'(exp_q.size()), 32'd0);
    data = 16'($urandom_range(0, 65535));
    mem_rdy = 1'b1;
    mem_rdata = data;
    push_ir(16'h0200, data);
    tick();
    mem_rdy = 1'b0;
    settle();
    pop_ir();

    // Redirect together with ack counts as a redirect.
    ir_ack = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0300;
    settle();
    chk("rda_pc_ld", 32'(pc_ld), 32'd1);
    tick();
    ir_ack = 1'b0;
    redirect = 1'b0;
    settle();
    chk("rda_ir_valid", 32'(ir_valid), 32'd0);
    chk("rda_mem_addr", 32'(mem_addr), 32'h0300);

    // Data on the last REQ cycle before the limit still completes.
    for (int i = 0; i < 14; i++) begin
      tick();
      settle();
    end
    chk("edge_state_req", 32'(dbg_state), 32'(ST_REQ));
    data = 16'($urandom_range(0, 65535));
    mem_rdy = 1'b1;
    mem_rdata = data;
    push_ir(16'h0300, data);
    tick();
    mem_rdy = 1'b0;
    settle();
    pop_ir();
    chk("edge_no_err", 32'(fetch_err), 32'd0);

    // Timeout: fifteen REQ cycles with no data.
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    settle();
    for (int i = 0; i < 15; i++) begin
      chk("to_wait_mem_rd", 32'(mem_rd), 32'd1);
      chk("to_wait_err", 32'(fetch_err), 32'd0);
      tick();
      settle();
    end
    chk("to_fetch_err", 32'(fetch_err), 32'd1);
    chk("to_state_err", 32'(dbg_state), 32'(ST_ERR));
    chk("to_mem_rd", 32'(mem_rd), 32'd0);
    redirect = 1'b1;
    redirect_pc = 16'h0400;
    settle();
    chk("to_redirect_ignored", 32'(pc_ld), 32'd0);
    tick();
    redirect = 1'b0;
    settle();
    chk("to_err_sticky", 32'(fetch_err), 32'd1);
    chk("to_ir_valid", 32'(ir_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("to_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("to_rst_err", 32'(fetch_err), 32'd0);

    // Reset in the second REQ cycle.
    tick();
    settle();
    chk("mr_req_addr", 32'(mem_addr), 32'h0010);
    tick();
    rst = 1'b1;
    mem_rdy = 1'b1;
    mem_rdata = 16'hBEEF;
    settle();
    chk("mr_mem_rd", 32'(mem_rd), 32'd0);
    chk("mr_pc_inc", 32'(pc_inc), 32'd0);
    tick();
    rst = 1'b0;
    mem_rdy = 1'b0;
    en = 1'b0;
    settle();
    chk("mr_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mr_ir_valid", 32'(ir_valid), 32'd0);
    chk("mr_ir_out", 32'(ir_out), 32'd0);
    chk("mr_ir_pc", 32'(ir_pc), 32'd0);
    chk("mr_fetch_err", 32'(fetch_err), 32'd0);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer sitting directly downstream of the 16-bit program counter and upstream of decode. It reads the current PC value and issues a memory read at that address. It captures the returned word into a one-entry instruction register, pulses the PC's increment input on a successful fetch, and drives the PC's load input on a branch/jump redirect. It also detects a stalled memory and reports a sticky fetch error.

## Interface
- W, 16, address and instruction width (matches PC width)
- TIMEOUT, 15, max cycles in REQ without mem_rdy before error (1..255)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  fetch enable, sampled in IDLE and on ack
- pc_val  input  W  current PC output
- pc_inc  output  1  PC increment request (combinational)
- pc_ld  output  1  PC load request (combinational)
- pc_ld_val  output  W  PC load value, equals redirect_pc
- mem_rd  output  1  read request
- mem_addr  output  W  read address
- mem_rdy  input  1  read data valid this cycle
- mem_rdata  input  W  read data
- ir_out  output  W  registered instruction
- ir_pc  output  W  address ir_out was fetched from
- ir_valid  output  1  ir_out holds an unconsumed instruction
- ir_ack  input  1  decode consumes ir_out this cycle
- redirect  input  1  branch/jump taken, flush and reload PC
- redirect_pc  input  W  new PC target
- fetch_err  output  1  sticky memory-timeout flag

## Operation
- States: IDLE, REQ, FULL, ERR.
- IDLE: mem_rd=0. Next state is REQ if en=1, otherwise IDLE.
- REQ: mem_rd=1, mem_addr=pc_val, held stable until mem_rdy or exit.
  - On mem_rdy: ir_out<=mem_rdata, ir_pc<=pc_val, ir_valid<=1, and pc_inc=1 in the same cycle, so PC and IR update on one edge. Next state FULL.
- FULL: mem_rd=0, ir_valid=1.
  - On ir_ack: ir_valid<=0. Next state is REQ if en=1, otherwise IDLE.
  - ir_valid is never set without a prior ack, so an instruction cannot be lost.
- Redirect (IDLE/REQ/FULL): pc_ld=1, pc_inc forced 0, and ir_valid<=0. Next state is REQ if en=1, otherwise IDLE.
  - Any outstanding read is abandoned: mem_rd drops for one cycle.
  - A mem_rdy coinciding with redirect is discarded.
  - A redirect coinciding with ir_ack is treated as a redirect.
- Memory protocol: mem_rdy is only meaningful while mem_rd=1. Deasserting mem_rd cancels the request.
- Timeout: wait counter cleared on entry to REQ, incremented each REQ cycle without mem_rdy.
  - When the counter reaches TIMEOUT, the next state is ERR.
  - mem_rdy arriving in the same cycle as the count reaching TIMEOUT wins and completes normally.
- ERR: fetch_err=1, mem_rd=0, ir_valid=0, pc_inc=pc_ld=0. Redirect and en are ignored. Only rst exits ERR.

## Timing
- Reset values: state IDLE, ir_out=0, ir_pc=0, ir_valid=0, fetch_err=0, wait counter=0.
- While rst=1, mem_rd, pc_inc and pc_ld are forced to 0.
- Zero-wait memory (mem_rdy in the first REQ cycle):
  - REQ to FULL in 1 cycle.
  - ir_valid is high the cycle after mem_rdy.
  - With ack in the first FULL cycle, REQ is re-entered one cycle later.
  - Throughput: 1 instruction per 2 cycles.
- Fetch latency: N wait cycles gives ir_valid at N+1 cycles after REQ entry.
- PC sees pc_inc and pc_ld in the same cycle as the triggering event; the new pc_val is visible the next cycle.
- pc_inc and pc_ld are never both 1.
- The counter saturates at TIMEOUT; ERR is reached TIMEOUT cycles after REQ entry.
- Reset mid-request: mem_rd=0 in the reset cycle; state IDLE on the next edge; no pc_inc.

## Structure
- Package fetch_pkg holds:
  - the state enum (IDLE=2'd0, REQ=2'd1, FULL=2'd2, ERR=2'd3)
  - the default W and TIMEOUT constants.
- Sub-module fetch_timer: 8-bit saturating wait counter.
  - Ports: clr, cnt_en, limit.
  - Output: expired.
- fetch_unit holds the FSM, IR registers and combinational PC/memory outputs.

## Test plan
- Zero-wait fetch:
  - Stimulus: reset, en=1, pc_val=16'h0010, mem_rdy=1 in the first REQ cycle with rdata=16'hA5A5.
  - Required: pc_inc pulses for 1 cycle; next cycle ir_out=A5A5, ir_pc=0010, ir_valid=1.
- Backpressure:
  - Stimulus: hold ir_ack=0 for 5 cycles.
  - Required: ir_valid stays 1, mem_rd=0, no pc_inc. ir_ack=1 gives ir_valid=0 and REQ next cycle.
- Wait states:
  - Stimulus: mem_rdy arrives after 3 wait cycles.
  - Required: mem_addr stable for 4 cycles; ir_valid high on cycle 5.
- Redirect:
  - Stimulus: redirect=1, redirect_pc=16'h0200, coinciding with mem_rdy.
  - Required: pc_ld=1, pc_ld_val=0200, pc_inc=0, data discarded; next REQ uses address 0200.
- Timeout:
  - Stimulus: TIMEOUT=15, mem_rdy held 0.
  - Required: fetch_err=1 after 15 REQ cycles; mem_rd=0; redirect ignored; rst clears the error to IDLE.
- Reset mid-request:
  - Stimulus: rst asserted in the second REQ cycle.
  - Required: mem_rd=0 that cycle; all outputs at reset values next cycle.
